pll_freq_check: RTL

Single-clock frequency checker that consumes the divided PLL-domain toggle (a high bit of the PLL-clocked counter) and measures it against the board reference clock. It synchronises the toggle, counts its rising edges over a fixed gate window of reference-clock cycles, and publishes each count together with a pass/fail verdict. The verdict drives the two-LED board outputs, replacing the raw counter-bit LED display with a self-checking PLL bring-up indicator.

---
 rtl/pll_freq_check.sv | 110 +++++++++++
 1 files changed

// File: rtl/pll_freq_check.sv
// PLL frequency checker: counts synchronised rising edges of a PLL-domain toggle over a
// fixed reference-clock gate window and drives pass/fail LEDs. Optional: FREQCHK_STICKY_FAIL_EN.
module pll_freq_check #(
  parameter int     GATE_CYCLES = 12000000,
  parameter int     COUNT_W     = 24,
  parameter longint LO_LIMIT    = 0,
  parameter longint HI_LIMIT    = (longint'(1) << COUNT_W) - 1
) (
  input  logic               i_clock,
  input  logic               i_resetn,
  input  logic               i_tick,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_valid,
  output logic               o_2LEDA,
  output logic               o_2LEDB
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
  localparam logic [COUNT_W-1:0] LO        = LO_LIMIT[COUNT_W-1:0];
  localparam logic [COUNT_W-1:0] HI        = HI_LIMIT[COUNT_W-1:0];

  typedef enum logic [0:0] {WARMUP, MEASURE} state_t;

  state_t              state;
  logic [1:0]          warm_cnt;
  logic                s1, s2, h;
  logic [GATE_W-1:0]   gate;
  logic [COUNT_W-1:0]  edge_cnt;
`ifdef FREQCHK_STICKY_FAIL_EN
  logic                sticky;
`endif

  logic                tick_edge;
  logic [COUNT_W-1:0]  final_cnt;
  logic [COUNT_W:0]    lo_diff, hi_diff;
  logic                in_range;

  // Saturating count including this cycle's edge; range test by borrow bits so that
  // full-scale limits never produce constant comparisons.
  always_comb begin
    tick_edge = s2 & ~h;
    final_cnt = edge_cnt;
    if (tick_edge && (edge_cnt != CNT_MAX))
      final_cnt = edge_cnt + COUNT_W'(1);
    lo_diff  = {1'b0, final_cnt} - {1'b0, LO};
    hi_diff  = {1'b0, HI} - {1'b0, final_cnt};
    in_range = ~lo_diff[COUNT_W] & ~hi_diff[COUNT_W];
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      state    <= WARMUP;
      warm_cnt <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      h        <= 1'b0;
      gate     <= '0;
      edge_cnt <= '0;
      o_count  <= '0;
      o_valid  <= 1'b0;
      o_2LEDA  <= 1'b0;
      o_2LEDB  <= 1'b0;
`ifdef FREQCHK_STICKY_FAIL_EN
      sticky   <= 1'b0;
`endif
    end else begin
      s1      <= i_tick;
      s2      <= s1;
      h       <= s2;
      o_valid <= 1'b0;
      case (state)
        WARMUP: begin
          warm_cnt <= warm_cnt + 2'd1;
          if (warm_cnt == 2'd2) begin
            state    <= MEASURE;
            gate     <= '0;
            edge_cnt <= '0;
          end
        end
        MEASURE: begin
          if (gate == GATE_LAST) begin
            o_count  <= final_cnt;
            o_valid  <= 1'b1;
            gate     <= '0;
            edge_cnt <= '0;
`ifdef FREQCHK_STICKY_FAIL_EN
            if (!in_range || sticky) begin
              sticky  <= 1'b1;
              o_2LEDA <= 1'b0;
              o_2LEDB <= 1'b1;
            end else begin
              o_2LEDA <= 1'b1;
              o_2LEDB <= 1'b0;
            end
`else
            o_2LEDA  <= in_range;
            o_2LEDB  <= ~in_range;
`endif
          end else begin
            gate     <= gate + GATE_W'(1);
            edge_cnt <= final_cnt;
          end
        end
      endcase
    end
  end

endmodule
